// File: rtl/jtag_uart_bridge.sv
// rtl/jtag_uart_bridge.sv - CPU<->JTAG byte channel with async TX/RX FIFOs
// Purpose: CPU register port on clk; BSCAN user DR on jtag_tck; gray-pointer FIFOs between.
// Ports:   clk/rstn             CPU clock, sync active-low reset (also synchronised onto tck)
//          cpu_req/wr/addr/wdata  register access strobe; cpu_ack/cpu_rdata one cycle later
//          irq                  registered level interrupt
//          jtag_*               tap clock, DR select, capture/shift/update, tdi in, tdo out

module jtag_uart_afifo #(
   parameter int W           = 8,
   parameter int DEPTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic         i_wclk,
   input  logic         i_wrstn,
   input  logic         i_push,
   input  logic [W-1:0] i_wdata,
   output logic         o_full,
   output logic [7:0]   o_wlevel,
   input  logic         i_rclk,
   input  logic         i_rrstn,
   input  logic         i_pop,
   output logic [W-1:0] o_rdata,
   output logic         o_empty,
   output logic [7:0]   o_rlevel
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   // Full when the two MSBs of the gray pointers differ and the rest match.
   localparam logic [PW-1:0] FULL_XOR = PW'(3) << (AW - 1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wbin, r_wgray, r_rbin, r_rgray;
   logic [PW-1:0] r_wsync [SYNC_STAGES];
   logic [PW-1:0] r_rsync [SYNC_STAGES];
   logic [PW-1:0] w_wbin_next, w_rbin_next;
   logic          w_do_push, w_do_pop;

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   // Write side: full/level judged against the synchronised (possibly stale) read pointer.
   assign o_full      = ((r_wgray ^ r_rsync[SYNC_STAGES-1]) == FULL_XOR);
   assign w_do_push   = i_push && !o_full;
   assign w_wbin_next = r_wbin + PW'(1);
   assign o_wlevel    = 8'(r_wbin - gray2bin(r_rsync[SYNC_STAGES-1]));

   always_ff @(posedge i_wclk) begin
      if (!i_wrstn) begin
         r_wbin  <= '0;
         r_wgray <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) r_rsync[i] <= '0;
      end else begin
         r_rsync[0] <= r_rgray;
         for (int i = 1; i < SYNC_STAGES; i++) r_rsync[i] <= r_rsync[i-1];
         if (w_do_push) begin
            r_wbin  <= w_wbin_next;
            r_wgray <= w_wbin_next ^ (w_wbin_next >> 1);
         end
      end
   end

   always_ff @(posedge i_wclk) begin
      if (w_do_push) r_mem[r_wbin[AW-1:0]] <= i_wdata;
   end

   // Read side: first-word-fall-through head.
   assign o_empty     = (r_rgray == r_wsync[SYNC_STAGES-1]);
   assign w_do_pop    = i_pop && !o_empty;
   assign w_rbin_next = r_rbin + PW'(1);
   assign o_rdata     = r_mem[r_rbin[AW-1:0]];
   assign o_rlevel    = 8'(gray2bin(r_wsync[SYNC_STAGES-1]) - r_rbin);

   always_ff @(posedge i_rclk) begin
      if (!i_rrstn) begin
         r_rbin  <= '0;
         r_rgray <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) r_wsync[i] <= '0;
      end else begin
         r_wsync[0] <= r_wgray;
         for (int i = 1; i < SYNC_STAGES; i++) r_wsync[i] <= r_wsync[i-1];
         if (w_do_pop) begin
            r_rbin  <= w_rbin_next;
            r_rgray <= w_rbin_next ^ (w_rbin_next >> 1);
         end
      end
   end
endmodule

module jtag_uart_bridge #(
   parameter int DATA_W      = 8,
   parameter int TX_DEPTH    = 16,
   parameter int RX_DEPTH    = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cpu_req,
   input  logic        cpu_wr,
   input  logic [1:0]  cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        cpu_ack,
   output logic        irq,
   input  logic        jtag_tck,
   input  logic        jtag_sel,
   input  logic        jtag_capture,
   input  logic        jtag_shift,
   input  logic        jtag_update,
   input  logic        jtag_tdi,
   output logic        jtag_tdo
);
   localparam int FRAME = DATA_W + 2;
   localparam int CW    = $clog2(FRAME + 2);

   logic [SYNC_STAGES-1:0] r_trst_sync, r_tgl_sync;
   logic [FRAME-1:0]       r_shreg;
   logic [CW-1:0]          r_bitcnt;
   logic                   r_cap_valid, r_ovf_tgl, r_tgl_prev;
   logic                   r_ack, r_irq, r_tx_ovf, r_rx_ovf;
   logic [15:0]            r_rdata, w_rdata_next;
   logic [1:0]             r_irq_en;
   logic                   w_trstn, w_frame_ok, w_tx_pop, w_rx_push;
   logic                   w_tx_full, w_tx_empty_t, w_rx_full_t, w_rx_empty;
   logic                   w_tx_push, w_rx_pop, w_st_wr;
   logic [DATA_W-1:0]      w_tx_head, w_rx_head;
   logic [7:0]             w_tx_level, w_rx_level, w_tx_rlevel_unused, w_rx_wlevel_unused;
   logic                   w_wdata_unused;

   assign w_wdata_unused = ^cpu_wdata;

   jtag_uart_afifo #(.W(DATA_W), .DEPTH(TX_DEPTH), .SYNC_STAGES(SYNC_STAGES)) u_tx (
      .i_wclk(clk), .i_wrstn(rstn), .i_push(w_tx_push), .i_wdata(cpu_wdata[DATA_W-1:0]),
      .o_full(w_tx_full), .o_wlevel(w_tx_level),
      .i_rclk(jtag_tck), .i_rrstn(w_trstn), .i_pop(w_tx_pop), .o_rdata(w_tx_head),
      .o_empty(w_tx_empty_t), .o_rlevel(w_tx_rlevel_unused));

   jtag_uart_afifo #(.W(DATA_W), .DEPTH(RX_DEPTH), .SYNC_STAGES(SYNC_STAGES)) u_rx (
      .i_wclk(jtag_tck), .i_wrstn(w_trstn), .i_push(w_rx_push), .i_wdata(r_shreg[DATA_W-1:0]),
      .o_full(w_rx_full_t), .o_wlevel(w_rx_wlevel_unused),
      .i_rclk(clk), .i_rrstn(rstn), .i_pop(w_rx_pop), .o_rdata(w_rx_head),
      .o_empty(w_rx_empty), .o_rlevel(w_rx_level));

   // ---------------- tck domain ----------------
   always_ff @(posedge jtag_tck) r_trst_sync <= {r_trst_sync[SYNC_STAGES-2:0], rstn};
   assign w_trstn = r_trst_sync[SYNC_STAGES-1];

   // Only a frame of exactly FRAME shifts is acted on at Update.
   assign w_frame_ok = jtag_sel && jtag_update && (r_bitcnt == CW'(FRAME));
   assign w_tx_pop   = w_frame_ok && r_cap_valid;
   assign w_rx_push  = w_frame_ok && r_shreg[DATA_W];
   assign jtag_tdo   = r_shreg[0];

   always_ff @(posedge jtag_tck) begin
      if (!w_trstn) begin
         r_shreg     <= '0;
         r_bitcnt    <= '0;
         r_cap_valid <= 1'b0;
         r_ovf_tgl   <= 1'b0;
      end else if (jtag_sel) begin
         if (jtag_capture) begin
            r_shreg     <= {!w_rx_full_t, !w_tx_empty_t, w_tx_head};
            r_bitcnt    <= '0;
            r_cap_valid <= !w_tx_empty_t;
         end else if (jtag_shift) begin
            r_shreg <= {jtag_tdi, r_shreg[FRAME-1:1]};
            if (r_bitcnt != CW'(FRAME + 1)) r_bitcnt <= r_bitcnt + CW'(1);
         end else if (jtag_update) begin
            // RX overflow crosses to clk as a toggle event.
            if (w_rx_push && w_rx_full_t) r_ovf_tgl <= ~r_ovf_tgl;
            // A repeated Update without a new Capture must not pop/push again.
            r_cap_valid <= 1'b0;
            r_bitcnt    <= '0;
         end
      end
   end

   // ---------------- clk domain ----------------
   always_comb begin
      w_rdata_next = '0;
      w_rx_pop     = 1'b0;
      w_tx_push    = cpu_req && cpu_wr && (cpu_addr == 2'd0);
      w_st_wr      = cpu_req && cpu_wr && (cpu_addr == 2'd2);
      if (cpu_req && !cpu_wr) begin
         case (cpu_addr)
            2'd0: if (!w_rx_empty) begin
               w_rdata_next[DATA_W]     = 1'b1;
               w_rdata_next[DATA_W-1:0] = w_rx_head;
               w_rx_pop                 = 1'b1;
            end
            2'd1:    w_rdata_next = {w_rx_level, w_tx_level};
            2'd2:    w_rdata_next = {11'd0, r_rx_ovf, r_tx_ovf, w_rx_empty,
                                     (w_tx_level == 8'd0), w_tx_full};
            default: w_rdata_next = {14'd0, r_irq_en};
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_ack      <= 1'b0;
         r_rdata    <= '0;
         r_irq      <= 1'b0;
         r_irq_en   <= '0;
         r_tx_ovf   <= 1'b0;
         r_rx_ovf   <= 1'b0;
         r_tgl_sync <= '0;
         r_tgl_prev <= 1'b0;
      end else begin
         r_ack      <= cpu_req;
         r_rdata    <= w_rdata_next;
         r_tgl_sync <= {r_tgl_sync[SYNC_STAGES-2:0], r_ovf_tgl};
         r_tgl_prev <= r_tgl_sync[SYNC_STAGES-1];
         // Clear first so a same-cycle new event keeps the flag set.
         if (w_st_wr && cpu_wdata[3]) r_tx_ovf <= 1'b0;
         if (w_st_wr && cpu_wdata[4]) r_rx_ovf <= 1'b0;
         if (w_tx_push && w_tx_full) r_tx_ovf <= 1'b1;
         if (r_tgl_sync[SYNC_STAGES-1] != r_tgl_prev) r_rx_ovf <= 1'b1;
         if (cpu_req && cpu_wr && (cpu_addr == 2'd3)) r_irq_en <= cpu_wdata[1:0];
         r_irq <= |(r_irq_en & {(w_tx_level == 8'd0), !w_rx_empty});
      end
   end

   assign cpu_ack   = r_ack;
   assign cpu_rdata = r_rdata;
   assign irq       = r_irq;
endmodule
